lfsr_gen: RTL
=============

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 128; state and output width in bits; legal range 8 or more.
REQ-002 Parameter POLY, default WIDTH'h2800_0005; Galois feedback mask with bits 0, 2, 27 and 29 set; POLY[0] SHALL be 1.
REQ-003 Parameter SEED, default 128'd123456789012345678901234567890123456789; reset and zero-seed substitute value; SHALL be nonzero.
REQ-004 Parameter STEPS, default 1; LFSR steps applied per accepted request; legal range 1..WIDTH.
REQ-005 Parameter CNT_W, default 32; width of the advance counter.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 load  in  1  seed load strobe.
REQ-009 seed  in  WIDTH  seed value, sampled when load=1.
REQ-010 require  in  1  request for a new random word.
REQ-011 req_ready  out  1  request acceptance, combinational.
REQ-012 random  out  WIDTH  current LFSR state, registered.
REQ-013 rd_valid  out  1  random holds an unconsumed fresh word.
REQ-014 rd_ready  in  1  consumer accepts the word while rd_valid=1.
REQ-015 lockup  out  1  sticky flag: a zero seed was substituted.
REQ-016 adv_count  out  CNT_W  number of accepted requests since reset or last load.

Function
REQ-017 Step function: f(s) = (s<<1)[WIDTH-1:0] XOR (s[WIDTH-1] ? POLY : 0).
REQ-018 Advance: one accepted request SHALL replace state with f applied STEPS times, all within a single cycle.
REQ-019 req_ready SHALL equal !rd_valid OR rd_ready.
REQ-020 A request is accepted when require=1, req_ready=1, load=0 and rst=0.
REQ-021 Latency: a request accepted at edge k SHALL update random, and set rd_valid=1, at edge k.
REQ-022 rd_valid SHALL clear at an edge where rd_valid=1, rd_ready=1 and no request is accepted.
REQ-023 Simultaneous consume and accept: random advances and rd_valid stays 1.
REQ-024 require=1 with req_ready=0: random, rd_valid and adv_count SHALL hold.
REQ-025 Priority: rst > load > require.
REQ-026 load=1 with seed≠0: state←seed, rd_valid←0, adv_count←0; lockup unchanged.
REQ-027 load=1 with seed=0: state←SEED, lockup←1, rd_valid←0, adv_count←0.
REQ-028 adv_count SHALL increment by 1 per accepted request and wrap from 2^CNT_W-1 to 0.
REQ-029 The state SHALL never become zero; this follows from REQ-027 and POLY[0]=1.

Reset
REQ-030 While rst=1 at an edge: random=SEED, rd_valid=0, lockup=0, adv_count=0; require and load are ignored.
REQ-031 Reset mid-operation SHALL discard any pending word; req_ready=1 in the cycle after reset.

Verification
REQ-032 WIDTH=8, POLY=8'h1D, SEED=8'h01, STEPS=1, rd_ready=1, require=1 for 9 cycles -> random = 02, 04, 08, 10, 20, 40, 80, 1D, 3A; adv_count=9.
REQ-033 Same config, STEPS=4, one request -> random=10; STEPS=8, one request -> random=1D.
REQ-034 Same config, STEPS=1, rd_ready=0, require held high 3 cycles -> random=02, rd_valid=1, req_ready=0, adv_count=1; then rd_ready=1 with require=1 -> random=04, rd_valid stays 1.
REQ-035 load=1, seed=0, require=1 in the same cycle -> random=SEED, lockup=1, rd_valid=0, adv_count=0; a following rst=1 -> lockup=0.
REQ-036 8-bit config, 255 accepted requests from 01 -> random=01 again with no intermediate 01 and never 00; CNT_W=8 after 256 requests -> adv_count=0.
REQ-037 Default config, 1000 random require/rd_ready/load patterns -> random matches a software model of REQ-017 through REQ-028 every cycle.

Source files
------------

// File: rtl/lfsr_gen.sv
// Galois LFSR random word source: STEPS steps per accepted request, result visible at the same edge.
// Backpressure: req_ready = !rd_valid | rd_ready; load/zero-seed substitution clears the pending word.
module lfsr_gen #(
   parameter int               WIDTH = 128,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(30'h2800_0005),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(128'd123456789012345678901234567890123456789),
   parameter int               STEPS = 1,
   parameter int               CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             require,
   output logic             req_ready,
   output logic [WIDTH-1:0] random,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             lockup,
   output logic [CNT_W-1:0] adv_count
);

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] state_nxt;
   logic             accept;

   assign req_ready = !rd_valid || rd_ready;
   assign accept    = require && req_ready && !load;
   assign random    = state;

   // Unrolled chain of STEPS Galois shifts, evaluated in one cycle.
   always_comb begin
      state_nxt = state;
      for (int i = 0; i < STEPS; i++) begin
         state_nxt = {state_nxt[WIDTH-2:0], 1'b0} ^ (state_nxt[WIDTH-1] ? POLY : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEED;
         rd_valid  <= 1'b0;
         lockup    <= 1'b0;
         adv_count <= '0;
      end else if (load) begin
         rd_valid  <= 1'b0;
         adv_count <= '0;
         if (seed == '0) begin
            state  <= SEED;
            lockup <= 1'b1;
         end else begin
            state  <= seed;
         end
      end else if (accept) begin
         state     <= state_nxt;
         rd_valid  <= 1'b1;
         adv_count <= adv_count + CNT_W'(1);
      end else if (rd_valid && rd_ready) begin
         rd_valid  <= 1'b0;
      end
   end

endmodule
